// File: rtl/sys_reset_seq.sv
// Reset sequencer: waits for stable PLL lock, then releases core and peripheral resets in stages.
// Re-asserts both resets on lock loss or a debounced button press, and counts lock losses.
module sys_reset_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int DEBOUNCE_CYCLES    = 50000,
  parameter int CNT_W              = 8
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             btn_n,
  output logic             rst_core,
  output logic             rst_periph,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam int CMAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ?
                        LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(CMAX);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    HOLD, STABLE, CORE, RUN
  } state_e;

  logic          sync1_q, sync2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          stable_q, stable_d;
  logic          press;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] llc_q, llc_d;
  logic             core_q, core_d;
  logic             periph_q, periph_d;
  logic             ready_q, ready_d;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      db_cnt_q <= '0;
      stable_q <= 1'b1;
    end else begin
      sync1_q  <= btn_n;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  // Counter runs only while the synced level disagrees with the accepted one.
  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  assign press = ~stable_q;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      llc_q    <= '0;
      core_q   <= 1'b1;
      periph_q <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      llc_q    <= llc_d;
      core_q   <= core_d;
      periph_q <= periph_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    llc_d   = llc_q;
    case (state_q)
      HOLD: begin
        cnt_d = '0;
        if (pll_locked && !press) begin
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (!pll_locked || press) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = CORE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CORE, RUN: begin
        if (!pll_locked || press) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (!pll_locked && llc_q != '1) begin
            llc_d = llc_q + CNT_W'(1);
          end
        end else if (state_q == CORE) begin
          if (cnt_q == CW'(STAGE_GAP - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they switch on the same edge.
  always_comb begin
    core_d   = !(state_d == CORE || state_d == RUN);
    periph_d = (state_d != RUN);
    ready_d  = (state_d == RUN);
  end

  assign rst_core      = core_q;
  assign rst_periph    = periph_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = llc_q;

endmodule
